// File: rtl/mem_line_responder_if.sv
// -----------------------------------------------------------------------------
// mem_line_if
// Cache<->memory line-transfer bus.
//   master : cache side. Drives memRead/memWrite/memAddress/memWData/memWrValid,
//            observes memWrReady/memRData/memRdValid/memDone/memBusy.
//   slave  : memory responder side (directions reversed).
// -----------------------------------------------------------------------------
interface mem_line_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 32
);
    logic                 memRead;
    logic                 memWrite;
    logic [ADDR_SIZE-1:0] memAddress;
    logic [DATA_SIZE-1:0] memWData;
    logic                 memWrValid;
    logic                 memWrReady;
    logic [DATA_SIZE-1:0] memRData;
    logic                 memRdValid;
    logic                 memDone;
    logic                 memBusy;

    modport master (
        output memRead, memWrite, memAddress, memWData, memWrValid,
        input  memWrReady, memRData, memRdValid, memDone, memBusy
    );

    modport slave (
        input  memRead, memWrite, memAddress, memWData, memWrValid,
        output memWrReady, memRData, memRdValid, memDone, memBusy
    );
endinterface

// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
// Memory-side responder serving cache line refills (burst read after a fixed
// access latency) and dirty-line writebacks (burst write with stall support).
// Requests are accepted only in IDLE; requests raised while busy are ignored.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-low reset (storage array is not cleared)
//   bus    : mem_line_if.slave - request/address/data handshake with the cache
// -----------------------------------------------------------------------------
module mem_line_responder #(
    parameter int ADDR_SIZE      = 16,
    parameter int DATA_SIZE      = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 3,
    parameter int DEPTH          = 1024
) (
    input  logic       clk,
    input  logic       reset,
    mem_line_if.slave  bus
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LINE_W = IDX_W - OFF_W;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [OFF_W-1:0] OFF_ZERO = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_BURST_RD = 3'd2,
        ST_BURST_WR = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                state_q;
    logic [LINE_W-1:0]     line_q;
    logic [OFF_W-1:0]      off_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_ready_q;
    logic                  rd_valid_q;
    logic [DATA_SIZE-1:0]  rd_data_q;
    logic                  done_q;
    logic                  busy_q;
    logic [DATA_SIZE-1:0]  mem_q [DEPTH];

    logic [IDX_W-1:0]      idx_s;
    logic [LINE_W-1:0]     req_line_s;
    logic                  unused_addr_s;

    // The line offset lives in off_q, so base+offset never leaves the line.
    assign idx_s      = {line_q, off_q};
    // Line index = (memAddress mod DEPTH) with the word-offset bits dropped.
    assign req_line_s = bus.memAddress[IDX_W-1:OFF_W];
    // Address bits above the array and the in-line offset bits are ignored.
    assign unused_addr_s = ^bus.memAddress;

    assign bus.memWrReady = wr_ready_q;
    assign bus.memRdValid = rd_valid_q;
    assign bus.memRData   = rd_data_q;
    assign bus.memDone    = done_q;
    assign bus.memBusy    = busy_q;

    // Transfer FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            line_q     <= {LINE_W{1'b0}};
            off_q      <= OFF_ZERO;
            cnt_q      <= CNT_ZERO;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_SIZE{1'b0}};
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q     <= 1'b0;
                    rd_valid_q <= 1'b0;
                    // Writeback wins when both requests are raised together.
                    if (bus.memWrite) begin
                        state_q    <= ST_BURST_WR;
                        line_q     <= req_line_s;
                        off_q      <= OFF_ZERO;
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (bus.memRead) begin
                        state_q <= ST_WAIT;
                        line_q  <= req_line_s;
                        off_q   <= OFF_ZERO;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // The edge leaving WAIT already presents word 0, so the
                    // first valid word appears LATENCY edges after acceptance.
                    if (cnt_q == CNT_ZERO) begin
                        state_q    <= ST_BURST_RD;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= mem_q[idx_s];
                        off_q      <= off_q + OFF_ONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_BURST_RD: begin
                    // off_q wrapping back to 0 means every word has been sent.
                    if (off_q == OFF_ZERO) begin
                        state_q    <= ST_DONE;
                        rd_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        rd_data_q <= mem_q[idx_s];
                        off_q     <= off_q + OFF_ONE;
                    end
                end
                ST_BURST_WR: begin
                    if (bus.memWrValid) begin
                        off_q <= off_q + OFF_ONE;
                        if (off_q == OFF_LAST) begin
                            state_q    <= ST_DONE;
                            wr_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            wr_ready_q <= 1'b1;
                        end
                    end else begin
                        wr_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b0;
                    rd_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Backing storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && (state_q == ST_BURST_WR) && bus.memWrValid) begin
            mem_q[idx_s] <= bus.memWData;
        end
    end
endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;
    localparam int WPL     = 4;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_line_if #(.ADDR_SIZE(16), .DATA_SIZE(32)) bus();

    mem_line_responder #(
        .ADDR_SIZE(16), .DATA_SIZE(32), .WORDS_PER_LINE(WPL),
        .LATENCY(LATENCY), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic [15:0] written_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference storage index: line base is address mod DEPTH rounded down to a line.
    function automatic int word_idx(input logic [15:0] addr, input int i);
        return ((int'(addr) % DEPTH) / WPL) * WPL + i;
    endfunction

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid refill word must match the next expected word.
    always @(negedge clk) begin
        if (bus.memRdValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h required=no_word", bus.memRData);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", {32'h0, bus.memRData}, {32'h0, mon_exp});
            end
        end
    end

    // gap_mode: 0 continuous, 1 fixed pattern 1,0,0,1,1,0,1, 2 random gaps
    task automatic do_write(input logic [15:0] addr, input logic [31:0] d [WPL],
                            input int gap_mode, input bit also_read);
        int idx;
        int step;
        bit v;
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.memAddress = addr;
        bus.memWrite   = 1'b1;
        bus.memRead    = also_read;
        wait_cycle();
        bus.memWrite   = 1'b0;
        bus.memRead    = 1'b0;
        bus.memAddress = 16'($urandom);
        check("wr_ready_start", {63'h0, bus.memWrReady}, 64'h1);
        check("wr_busy", {63'h0, bus.memBusy}, 64'h1);
        idx  = 0;
        step = 0;
        while (idx < WPL && step < 64) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = pat[step % 7];
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.memWrValid = v;
            bus.memWData   = v ? d[idx] : $urandom;
            wait_cycle();
            step++;
            if (v) begin
                model_mem[word_idx(addr, idx)] = d[idx];
                idx++;
            end
            if (idx < WPL) begin
                check("wr_ready_mid", {63'h0, bus.memWrReady}, 64'h1);
                check("wr_no_early_done", {63'h0, bus.memDone}, 64'h0);
            end
        end
        bus.memWrValid = 1'b0;
        check("wr_words_accepted", 64'(idx), 64'(WPL));
        check("wr_done", {63'h0, bus.memDone}, 64'h1);
        check("wr_ready_end", {63'h0, bus.memWrReady}, 64'h0);
        wait_cycle();
        check("wr_done_one_cycle", {63'h0, bus.memDone}, 64'h0);
        check("wr_idle", {63'h0, bus.memBusy}, 64'h0);
        written_q.push_back(addr);
    endtask

    task automatic do_read(input logic [15:0] addr, input bit pulse, input bit abort);
        int k;
        int n;
        for (int i = 0; i < WPL; i++) exp_q.push_back(model_mem[word_idx(addr, i)]);
        bus.memAddress = addr;
        bus.memRead    = 1'b1;
        wait_cycle();
        bus.memRead    = 1'b0;
        bus.memAddress = 16'($urandom);
        check("rd_busy", {63'h0, bus.memBusy}, 64'h1);
        k = 0;
        while (bus.memRdValid !== 1'b1 && k < 20) begin
            wait_cycle();
            k++;
        end
        check("rd_latency", 64'(k), 64'(LATENCY));
        n = 1;
        while (n < 16) begin
            if (abort && n == 2) begin
                reset = 1'b0;
                wait_cycle();
                check("rst_rdvalid", {63'h0, bus.memRdValid}, 64'h0);
                check("rst_rdata", {32'h0, bus.memRData}, 64'h0);
                check("rst_done", {63'h0, bus.memDone}, 64'h0);
                check("rst_busy", {63'h0, bus.memBusy}, 64'h0);
                check("rst_wrready", {63'h0, bus.memWrReady}, 64'h0);
                reset = 1'b1;
                exp_q.delete();
                return;
            end
            if (pulse && n == 2) bus.memRead = 1'b1;
            wait_cycle();
            bus.memRead = 1'b0;
            if (bus.memRdValid === 1'b1) n++;
            else break;
        end
        check("rd_burst_len", 64'(n), 64'(WPL));
        check("rd_done", {63'h0, bus.memDone}, 64'h1);
        wait_cycle();
        check("rd_done_one_cycle", {63'h0, bus.memDone}, 64'h0);
        check("rd_idle", {63'h0, bus.memBusy}, 64'h0);
        if (pulse) begin
            wait_cycle();
            check("rd_pulse_ignored", {63'h0, bus.memBusy}, 64'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d [WPL];
        logic [15:0] wa;
        logic [15:0] ra;
        reset          = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.memAddress = 16'h0;
        bus.memWData   = 32'h0;
        bus.memWrValid = 1'b0;
        repeat (3) wait_cycle();
        check("reset_busy", {63'h0, bus.memBusy}, 64'h0);
        check("reset_done", {63'h0, bus.memDone}, 64'h0);
        check("reset_rdvalid", {63'h0, bus.memRdValid}, 64'h0);
        check("reset_wrready", {63'h0, bus.memWrReady}, 64'h0);
        check("reset_rdata", {32'h0, bus.memRData}, 64'h0);
        reset = 1'b1;
        wait_cycle();

        // Basic writeback then refill of line 0x0040
        d = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        do_write(16'h0040, d, 0, 1'b0);
        do_read(16'h0040, 1'b0, 1'b0);

        // Writeback with valid gaps
        d = '{32'hB0000000, 32'hB1111111, 32'hB2222222, 32'hB3333333};
        do_write(16'h0080, d, 1, 1'b0);
        do_read(16'h0080, 1'b0, 1'b0);

        // Simultaneous read and write request: write must be taken
        d = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
        do_write(16'h00C0, d, 0, 1'b1);
        do_read(16'h00C2, 1'b0, 1'b0);

        // Read request pulsed during an active burst
        do_read(16'h0040, 1'b1, 1'b0);

        // Reset on the second refill word, then a clean refill
        do_read(16'h0080, 1'b0, 1'b1);
        wait_cycle();
        do_read(16'h0080, 1'b0, 1'b0);

        // Top address: words 0x3FC..0x3FF, offset and high bits ignored
        d = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
        do_write(16'hFFFF, d, 2, 1'b0);
        do_read(16'h03FC, 1'b0, 1'b0);
        do_read(16'h07FE, 1'b0, 1'b0);

        // Randomized writebacks and refills through address aliases
        for (int t = 0; t < 20; t++) begin
            wa = 16'($urandom);
            for (int i = 0; i < WPL; i++) d[i] = $urandom;
            do_write(wa, d, 2, 1'($urandom_range(0, 1)));
            wa = written_q[$urandom_range(0, written_q.size() - 1)];
            ra = (16'($urandom) & 16'hFC03) | (wa & 16'h03FC);
            do_read(ra, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) wait_cycle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
